fu_issue_ctrl: RTL



---
 rtl/fu_issue_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fu_issue_ctrl.sv
// Issue controller for one floating-point compute tile: gathers an operand pair,
// holds it on the tile buses until done, then offers the result. Optional macro: FU_TIMEOUT_EN.
`ifndef PATH_WIDTH
`define PATH_WIDTH 33
`endif

module fu_issue_ctrl #(
  parameter int META_BITS   = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        cfg_conf,
  input  logic [`PATH_WIDTH-META_BITS:0]    src0_data,
  input  logic                              src0_last,
  input  logic                              src0_valid,
  output logic                              src0_ready,
  input  logic [`PATH_WIDTH-META_BITS:0]    src1_data,
  input  logic                              src1_last,
  input  logic                              src1_valid,
  output logic                              src1_ready,
  output logic [`PATH_WIDTH:0]              fu_d_in_c0,
  output logic [`PATH_WIDTH:0]              fu_d_in_c1,
  output logic [3:0]                        fu_conf,
  input  logic [`PATH_WIDTH-1:0]            fu_d_out,
  input  logic                              fu_done,
  output logic [`PATH_WIDTH-2:0]            res_data,
  output logic                              res_last,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic                              fault
);

  localparam int OPW  = `PATH_WIDTH - META_BITS + 1;
  localparam int RESW = `PATH_WIDTH - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            a_held_q, a_held_d;
  logic            b_held_q, b_held_d;
  logic [OPW-1:0]  a_data_q, a_data_d;
  logic [OPW-1:0]  b_data_q, b_data_d;
  logic            a_last_q, a_last_d;
  logic            b_last_q, b_last_d;
  logic [3:0]      fu_conf_q, fu_conf_d;
  logic [RESW-1:0] res_data_q, res_data_d;
  logic            res_last_q, res_last_d;

`ifdef FU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            fault_q, fault_d;
  logic            tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d    = state_q;
    a_held_d   = a_held_q;
    b_held_d   = b_held_q;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    a_last_d   = a_last_q;
    b_last_d   = b_last_q;
    fu_conf_d  = fu_conf_q;
    res_data_d = res_data_q;
    res_last_d = res_last_q;
`ifdef FU_TIMEOUT_EN
    fault_d    = fault_q;
    tmo_cnt_d  = (state_q == ST_ISSUE) ? tmo_cnt_q + TW'(1) : '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (src0_valid && !a_held_q) begin
          a_held_d = 1'b1;
          a_data_d = src0_data;
          a_last_d = src0_last;
        end
        if (src1_valid && !b_held_q) begin
          b_held_d = 1'b1;
          b_data_d = src1_data;
          b_last_d = src1_last;
        end
        // Issue on the edge that completes the pair, so the second capture costs no extra cycle.
        if (a_held_d && b_held_d) begin
          state_d   = ST_ISSUE;
          fu_conf_d = cfg_conf;
        end
      end
      ST_ISSUE: begin
        if (fu_done) begin
          res_data_d = fu_d_out[`PATH_WIDTH-1:1];
          res_last_d = fu_d_out[0];
          state_d    = ST_OUT;
        end
`ifdef FU_TIMEOUT_EN
        else if (tmo_hit) begin
          fault_d    = 1'b1;
          res_data_d = '0;
          res_last_d = a_last_q;
          state_d    = ST_OUT;
        end
`endif
      end
      ST_OUT: begin
        if (res_ready) begin
          a_held_d = 1'b0;
          b_held_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_held_q   <= 1'b0;
      b_held_q   <= 1'b0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      a_last_q   <= 1'b0;
      b_last_q   <= 1'b0;
      fu_conf_q  <= '0;
      res_data_q <= '0;
      res_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_held_q   <= a_held_d;
      b_held_q   <= b_held_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      a_last_q   <= a_last_d;
      b_last_q   <= b_last_d;
      fu_conf_q  <= fu_conf_d;
      res_data_q <= res_data_d;
      res_last_q <= res_last_d;
    end
  end

`ifdef FU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      fault_q   <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Bus valid follows ISSUE directly: unbroken while issuing, low from the cycle after done.
  always_comb begin
    fu_d_in_c0 = '0;
    fu_d_in_c1 = '0;
    fu_d_in_c0[`PATH_WIDTH:META_BITS] = a_data_q;
    fu_d_in_c1[`PATH_WIDTH:META_BITS] = b_data_q;
    fu_d_in_c0[1] = a_last_q;
    fu_d_in_c1[1] = b_last_q;
    fu_d_in_c0[0] = (state_q == ST_ISSUE);
    fu_d_in_c1[0] = (state_q == ST_ISSUE);
  end

  assign src0_ready = !rst && (state_q == ST_IDLE) && !a_held_q;
  assign src1_ready = !rst && (state_q == ST_IDLE) && !b_held_q;
  assign fu_conf    = fu_conf_q;
  assign res_data   = res_data_q;
  assign res_last   = res_last_q;
  assign res_valid  = (state_q == ST_OUT);

endmodule
